// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional early-out for |dividend| < |divisor| enabled by defining DIV_EARLY_OUT_EN.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] div_operand_1_i,
  input  logic [XLEN-1:0] div_operand_2_i,
  input  logic            div_kill_i,
  input  logic            div_ack_i,
  output logic            div_busy_o,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;

  // Request decode: signedness, magnitudes, special-case detection
  logic            in_signed;
  logic [XLEN-1:0] abs1, abs2, spec_res;
  logic            special;

  assign in_signed = ~div_op_i[0];
  assign abs1 = (in_signed && div_operand_1_i[XLEN-1]) ? ('0 - div_operand_1_i) : div_operand_1_i;
  assign abs2 = (in_signed && div_operand_2_i[XLEN-1]) ? ('0 - div_operand_2_i) : div_operand_2_i;

  // Results that are known at acceptance and bypass the iteration
  always_comb begin
    special  = 1'b0;
    spec_res = '0;
    if (div_operand_2_i == '0) begin
      special  = 1'b1;
      spec_res = div_op_i[1] ? div_operand_1_i : '1;
    end else if (in_signed && div_operand_1_i == MOST_NEG && div_operand_2_i == '1) begin
      special  = 1'b1;
      spec_res = div_op_i[1] ? '0 : div_operand_1_i;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (abs1 < abs2) begin
      special  = 1'b1;
      spec_res = div_op_i[1] ? div_operand_1_i : '0;
    end
`endif
  end

  // One restoring step: quo_q shifts the dividend out while collecting quotient bits
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub, rem_n, quo_n, q_fin, r_fin;
  logic            rem_ge, op_signed;

  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = rem_sh >= {1'b0, dvs_q};
  // The true difference is below the divisor, so the low XLEN bits are exact
  assign rem_sub   = rem_sh[XLEN-1:0] - dvs_q;
  assign rem_n     = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
  assign quo_n     = {quo_q[XLEN-2:0], rem_ge};
  assign op_signed = ~op_q[0];
  assign q_fin     = (op_signed && (sgn1_q ^ sgn2_q)) ? ('0 - quo_n) : quo_n;
  assign r_fin     = (op_signed && sgn1_q) ? ('0 - rem_n) : rem_n;

  // Next-state and datapath control; kill overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sgn1_d  = sgn1_q;
    sgn2_d  = sgn2_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (div_req_i) begin
          op_d   = div_op_i;
          sgn1_d = div_operand_1_i[XLEN-1];
          sgn2_d = div_operand_2_i[XLEN-1];
          quo_d  = abs1;
          rem_d  = '0;
          dvs_d  = abs2;
          cnt_d  = '0;
          if (special) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          res_d   = op_q[1] ? r_fin : q_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        if (div_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (div_kill_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sgn1_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sgn1_q  <= sgn1_d;
      sgn2_q  <= sgn2_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
    end
  end

  assign div_busy_o   = (state_q != IDLE);
  assign div_valid_o  = (state_q == DONE);
  assign div_result_o = div_valid_o ? res_q : '0;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_div_iter;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            div_req_i = 1'b0;
  logic [1:0]      div_op_i = '0;
  logic [XLEN-1:0] div_operand_1_i = '0;
  logic [XLEN-1:0] div_operand_2_i = '0;
  logic            div_kill_i = 1'b0;
  logic            div_ack_i = 1'b0;
  logic            div_busy_o, div_valid_o;
  logic [XLEN-1:0] div_result_o;

  div_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_op_i(div_op_i),
    .div_operand_1_i(div_operand_1_i), .div_operand_2_i(div_operand_2_i),
    .div_kill_i(div_kill_i), .div_ack_i(div_ack_i),
    .div_busy_o(div_busy_o), .div_valid_o(div_valid_o), .div_result_o(div_result_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = '1; r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 0;
      end else begin
        q = sa / sb; r = sa % sb;
      end
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic longint mag(input logic sgn, input logic [31:0] v);
    longint x;
    x = sgn ? longint'($signed(v)) : longint'({32'h0, v});
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit s;
    s = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    if (b != 0 && mag(!op[0], a) < mag(!op[0], b)) s = 1'b1;
`endif
    return s;
  endfunction

  // Model state: an operation in flight, the cycle its result becomes visible, and the result
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_res = '0;

  always @(posedge clk) begin
    bit vis;
    vis = m_act && (cyc >= m_done_at);
    cyc++;
    if (rst || div_kill_i) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (div_req_i) begin
        m_act     = 1'b1;
        m_res     = ref_result(div_op_i, div_operand_1_i, div_operand_2_i);
        m_done_at = cyc + (is_special(div_op_i, div_operand_1_i, div_operand_2_i) ? 0 : XLEN);
      end
    end else if (vis && div_ack_i) begin
      m_act = 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    bit eb, ev;
    eb = m_act && !rst;
    ev = eb && (cyc >= m_done_at);
    chk("busy", {31'b0, div_busy_o}, {31'b0, eb});
    chk("valid", {31'b0, div_valid_o}, {31'b0, ev});
    chk("result", div_result_o, ev ? m_res : 32'h0);
  end

  // ---------------- directed helpers ----------------
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input int hold, input bit req_with_ack);
    int n;
    n = 0;
    @(posedge clk); #2;
    div_req_i = 1'b1; div_op_i = op; div_operand_1_i = a; div_operand_2_i = b;
    forever begin
      @(negedge clk);
      if (div_valid_o) break;
      if (n >= 100) break;
      @(posedge clk); #2;
      div_req_i = 1'b0;
      n++;
    end
    div_req_i = 1'b0;
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_valid required=valid_within_100", name);
      return;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_res"}, div_result_o, exp_res);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk({name, "_hold_valid"}, {31'b0, div_valid_o}, 32'd1);
      chk({name, "_hold_res"}, div_result_o, exp_res);
    end
    @(posedge clk); #2;
    div_ack_i = 1'b1;
    div_req_i = req_with_ack;
    @(posedge clk); #2;
    div_ack_i = 1'b0;
    div_req_i = 1'b0;
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'b0, div_busy_o}, 32'd0);
    chk({name, "_idle_res"}, div_result_o, 32'd0);
    @(negedge clk);
    chk({name, "_idle_busy2"}, {31'b0, div_busy_o}, 32'd0);
  endtask

  // Request in cycle 0; returns at cycle 1 with req dropped
  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    div_req_i = 1'b1; div_op_i = op; div_operand_1_i = a; div_operand_2_i = b;
    @(posedge clk); #2;
    div_req_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  localparam int EO_LAT = `ifdef DIV_EARLY_OUT_EN 1 `else 33 `endif;

  initial begin
    // Pin the reference model to hand-computed values
    chk("model_divu", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
    chk("model_remu", ref_result(2'b11, 32'd100, 32'd7), 32'd2);
    chk("model_div_n7_2", ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_n7_2", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_rem_7_n2", ref_result(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
    chk("model_div_ovf", ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, div_busy_o}, 32'd0);
    chk("reset_valid", {31'b0, div_valid_o}, 32'd0);
    chk("reset_result", div_result_o, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0, 1'b0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0, 1'b0);
    do_op("div_n7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 1'b0);
    do_op("rem_n7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 1'b0);
    do_op("div_7_n2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0, 1'b0);
    do_op("rem_7_n2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, 1'b0);
    do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
    do_op("divu_3_10", 2'b01, 32'd3, 32'd10, 32'd0, EO_LAT, 0, 1'b0);
    do_op("hold_ack", 2'b01, 32'd1000, 32'd9, 32'd111, 33, 10, 1'b1);

    // Kill during iteration 10
    start_req(2'b01, 32'd12345, 32'd7);
    repeat (10) @(posedge clk);
    #2 div_kill_i = 1'b1;
    @(posedge clk); #2;
    div_kill_i = 1'b0;
    @(negedge clk);
    chk("kill_busy", {31'b0, div_busy_o}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      chk("kill_no_valid", {31'b0, div_valid_o}, 32'd0);
    end
    do_op("after_kill", 2'b01, 32'd9, 32'd3, 32'd3, 33, 0, 1'b0);

    // Reset pulse during iteration 10
    start_req(2'b01, 32'd12345, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'b0, div_busy_o}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("rst_no_valid", {31'b0, div_valid_o}, 32'd0);
    end
    do_op("after_rst", 2'b01, 32'd9, 32'd3, 32'd3, 33, 0, 1'b0);

    // Randomized traffic, checked cycle by cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      div_req_i       = ($urandom_range(0, 1) == 1);
      div_op_i        = 2'($urandom_range(0, 3));
      div_operand_1_i = rand_operand();
      div_operand_2_i = rand_operand();
      div_ack_i       = ($urandom_range(0, 3) == 0);
      div_kill_i      = ($urandom_range(0, 63) == 0);
      rst             = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #2;
    div_req_i = 1'b0; div_ack_i = 1'b0; div_kill_i = 1'b0; rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port div_req_i  input  1  new divide request; sampled only in IDLE.
REQ-005 SHALL have port div_op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port div_operand_1_i  input  XLEN  dividend.
REQ-007 SHALL have port div_operand_2_i  input  XLEN  divisor.
REQ-008 SHALL have port div_kill_i  input  1  pipeline flush; abandons any operation.
REQ-009 SHALL have port div_ack_i  input  1  consumer accepts result in DONE.
REQ-010 SHALL have port div_busy_o  output  1  high in any state other than IDLE.
REQ-011 SHALL have port div_valid_o  output  1  result valid; high exactly in DONE.
REQ-012 SHALL have port div_result_o  output  XLEN  quotient or remainder per div_op_i.

Function
REQ-013 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-014 SHALL, in IDLE with div_req_i=1 and div_kill_i=0, register operands, op and operand signs at the edge.
REQ-015 SHALL, at that edge, go to DONE if the request is a special case (REQ-019, REQ-020); otherwise go to CALC with iteration counter 0.
REQ-016 SHALL, in CALC, perform one radix-2 restoring iteration per cycle on operand magnitudes (absolute values for DIV/REM, raw for DIVU/REMU).
REQ-017 SHALL go CALC->DONE at the edge completing iteration XLEN; a request in cycle 0 therefore yields div_valid_o first high in cycle XLEN+1 (33 for XLEN=32).
REQ-018 SHALL apply sign correction for signed ops: quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-019 SHALL, for divisor 0: quotient all ones; remainder = dividend; signed and unsigned alike.
REQ-020 SHALL, for DIV/REM with dividend = most-negative value and divisor all ones: quotient = dividend, remainder 0.
REQ-021 SHALL hold div_result_o and div_valid_o stable in DONE until div_ack_i=1, then go to IDLE at that edge.
REQ-022 SHALL not accept a new request in CALC or DONE; div_req_i is ignored there, including the DONE cycle in which div_ack_i=1.
REQ-023 SHALL, on div_kill_i=1 in any state, go to IDLE at the next edge with no result produced; kill takes priority over div_req_i and div_ack_i in the same cycle.
REQ-024 SHALL drive div_result_o to 0 when div_valid_o=0.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, counter 0, all internal registers 0, div_busy_o=0, div_valid_o=0, div_result_o=0.
REQ-026 SHALL, on rst asserted mid-operation, discard the operation immediately with no result ever presented.

Configuration
REQ-027 SHALL, when macro DIV_EARLY_OUT_EN is defined, treat |dividend| < |divisor| (non-zero divisor) as a special case: DONE at the acceptance edge, quotient 0, remainder = original dividend.
REQ-028 SHALL, when DIV_EARLY_OUT_EN is undefined, process such requests through the full XLEN-cycle CALC path with identical results.

Verification
REQ-029 SHALL cover: DIVU 100/7 requested in cycle 0 -> div_valid_o high from cycle 33, result 14; REMU same operands -> 2.
REQ-030 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
REQ-031 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, valid in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, valid in cycle 1.
REQ-032 SHALL cover: div_ack_i held low 10 cycles in DONE -> valid and result stable for 10 cycles; ack with simultaneous div_req_i -> IDLE, request not accepted.
REQ-033 SHALL cover: div_kill_i in CALC iteration 10 -> busy low next cycle, valid never asserted; next request DIVU 9/3 -> 3 with normal latency; rst pulse in CALC -> same outcome.
REQ-034 SHALL cover: DIVU 3/10 -> quotient 0, valid in cycle 1 with DIV_EARLY_OUT_EN defined, cycle 33 without.
